// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 command transmitter.
// Sends one byte as an 11-bit device-clocked frame and checks the device ACK.
// The PS/2 lines are only ever pulled low through the *_oe enables.
module ps2_host_tx #(
   parameter int unsigned INHIBIT_CYCLES = 5000,
   parameter int unsigned START_TIMEOUT  = 750000,
   parameter int unsigned XFER_TIMEOUT   = 100000
) (
   input  logic       CLOCK_50,
   input  logic       resetn,
   input  logic [7:0] cmd_data,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic       ps2_clk_in,
   input  logic       ps2_dat_in,
   output logic       ps2_clk_oe,
   output logic       ps2_dat_oe,
   output logic       tx_busy,
   output logic       tx_done,
   output logic       tx_error
);

   localparam int unsigned WAIT_MAX = (INHIBIT_CYCLES > START_TIMEOUT) ? INHIBIT_CYCLES : START_TIMEOUT;
   localparam int unsigned CNT_W    = $clog2(WAIT_MAX + 1);
   localparam int unsigned XCNT_W   = $clog2(XFER_TIMEOUT + 1);
   localparam int unsigned FRAME_W  = 10;
   localparam int unsigned IDX_W    = 4;

   typedef enum logic [3:0] {
      S_IDLE,
      S_INHIBIT,
      S_RTS,
      S_WAIT_FIRST,
      S_SHIFT,
      S_ACK,
      S_WAIT_IDLE,
      S_DONE,
      S_ERROR
   } state_t;

   state_t               state, state_d;
   logic [CNT_W-1:0]     cnt, cnt_d;
   logic [XCNT_W-1:0]    xcnt, xcnt_d;
   logic [IDX_W-1:0]     idx, idx_d;
   logic [FRAME_W-1:0]   frame, frame_d;
   logic                 dat_oe_d;

   logic clk_s1, clk_s2, clk_q;
   logic dat_s1, dat_s2;
   logic fall;
   logic xfer_exp;

   // Two-flop synchronizers for both lines plus a delayed clock copy for edge detection.
   // Reset to the idle-high level so no false edge appears after reset.
   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         clk_s1 <= 1'b1;
         clk_s2 <= 1'b1;
         clk_q  <= 1'b1;
         dat_s1 <= 1'b1;
         dat_s2 <= 1'b1;
      end else begin
         clk_s1 <= ps2_clk_in;
         clk_s2 <= clk_s1;
         clk_q  <= clk_s2;
         dat_s1 <= ps2_dat_in;
         dat_s2 <= dat_s1;
      end
   end

   assign fall     = clk_q & ~clk_s2;
   assign xfer_exp = (xcnt == XCNT_W'(XFER_TIMEOUT - 1));

   // Next-state, counters and next data-line enable.
   always_comb begin
      state_d  = state;
      cnt_d    = cnt;
      xcnt_d   = xcnt;
      idx_d    = idx;
      frame_d  = frame;
      dat_oe_d = ps2_dat_oe;
      case (state)
         S_IDLE: begin
            if (cmd_valid) begin
               frame_d = {1'b1, ~^cmd_data, cmd_data};
               cnt_d   = '0;
               state_d = S_INHIBIT;
            end
         end
         S_INHIBIT: begin
            cnt_d = cnt + CNT_W'(1);
            if (cnt == CNT_W'(INHIBIT_CYCLES - 1)) begin
               dat_oe_d = 1'b1;
               state_d  = S_RTS;
            end
         end
         S_RTS: begin
            cnt_d   = '0;
            state_d = S_WAIT_FIRST;
         end
         S_WAIT_FIRST: begin
            cnt_d = cnt + CNT_W'(1);
            if (fall) begin
               dat_oe_d = ~frame[0];
               idx_d    = IDX_W'(1);
               xcnt_d   = '0;
               state_d  = S_SHIFT;
            end else if (cnt == CNT_W'(START_TIMEOUT - 1)) begin
               state_d = S_ERROR;
            end
         end
         S_SHIFT: begin
            xcnt_d = xcnt + XCNT_W'(1);
            if (xfer_exp) begin
               state_d = S_ERROR;
            end else if (fall) begin
               dat_oe_d = ~frame[idx];
               idx_d    = idx + IDX_W'(1);
               if (idx == IDX_W'(FRAME_W - 1)) state_d = S_ACK;
            end
         end
         S_ACK: begin
            xcnt_d = xcnt + XCNT_W'(1);
            if (xfer_exp)  state_d = S_ERROR;
            else if (fall) state_d = dat_s2 ? S_ERROR : S_WAIT_IDLE;
         end
         S_WAIT_IDLE: begin
            xcnt_d = xcnt + XCNT_W'(1);
            if (xfer_exp)              state_d = S_ERROR;
            else if (clk_s2 && dat_s2) state_d = S_DONE;
         end
         S_DONE:  state_d = S_IDLE;
         S_ERROR: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      // Data line is only ever pulled from request-to-send until the stop bit.
      if (state_d != S_RTS && state_d != S_WAIT_FIRST && state_d != S_SHIFT) dat_oe_d = 1'b0;
   end

   // State, datapath and registered outputs; async reset releases both lines at once.
   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         state      <= S_IDLE;
         cnt        <= '0;
         xcnt       <= '0;
         idx        <= '0;
         frame      <= '0;
         ps2_clk_oe <= 1'b0;
         ps2_dat_oe <= 1'b0;
         tx_busy    <= 1'b0;
         tx_done    <= 1'b0;
         tx_error   <= 1'b0;
         cmd_ready  <= 1'b1;
      end else begin
         state      <= state_d;
         cnt        <= cnt_d;
         xcnt       <= xcnt_d;
         idx        <= idx_d;
         frame      <= frame_d;
         ps2_clk_oe <= (state_d == S_INHIBIT) || (state_d == S_RTS);
         ps2_dat_oe <= dat_oe_d;
         tx_busy    <= (state_d != S_IDLE);
         tx_done    <= (state_d == S_DONE);
         tx_error   <= (state_d == S_ERROR);
         cmd_ready  <= (state_d == S_IDLE);
      end
   end

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: directed + random transfers against a behavioural PS/2 device model.
module tb_ps2_host_tx;

   localparam int unsigned INH  = 50;
   localparam int unsigned STO  = 300;
   localparam int unsigned XTO  = 600;
   localparam int unsigned HALF = 20;

   logic       CLOCK_50 = 1'b0;
   logic       resetn;
   logic [7:0] cmd_data;
   logic       cmd_valid;
   logic       cmd_ready;
   logic       ps2_clk_in, ps2_dat_in;
   logic       ps2_clk_oe, ps2_dat_oe;
   logic       tx_busy, tx_done, tx_error;
   logic       dev_clk, dev_dat;

   int total = 0;
   int bad   = 0;

   ps2_host_tx #(
      .INHIBIT_CYCLES(INH),
      .START_TIMEOUT (STO),
      .XFER_TIMEOUT  (XTO)
   ) dut (
      .CLOCK_50  (CLOCK_50),
      .resetn    (resetn),
      .cmd_data  (cmd_data),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .ps2_clk_in(ps2_clk_in),
      .ps2_dat_in(ps2_dat_in),
      .ps2_clk_oe(ps2_clk_oe),
      .ps2_dat_oe(ps2_dat_oe),
      .tx_busy   (tx_busy),
      .tx_done   (tx_done),
      .tx_error  (tx_error)
   );

   // Open-drain wiring: either side may pull a line low.
   assign ps2_clk_in = dev_clk & ~ps2_clk_oe;
   assign ps2_dat_in = dev_dat & ~ps2_dat_oe;

   always #5 CLOCK_50 = ~CLOCK_50;

   // Cycle counter and event monitor.
   int   cyc = 0;
   int   done_n = 0, err_n = 0, both_n = 0, inh_n = 0, rts_n = 0;
   int   rel_cyc = 0, err_cyc = 0;
   logic clk_oe_q = 1'b0, err_q = 1'b0;

   always @(posedge CLOCK_50) cyc <= cyc + 1;

   always @(negedge CLOCK_50) begin
      if (tx_done) done_n++;
      if (tx_error) err_n++;
      if (tx_done && tx_error) both_n++;
      if (ps2_clk_oe && !ps2_dat_oe) inh_n++;
      if (ps2_clk_oe && ps2_dat_oe) rts_n++;
      if (clk_oe_q && !ps2_clk_oe) rel_cyc = cyc;
      if (!err_q && tx_error) err_cyc = cyc;
      clk_oe_q = ps2_clk_oe;
      err_q    = tx_error;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(negedge CLOCK_50);
         #1;
      end
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Expected on-wire bits after the start bit: data LSB first, odd parity, stop.
   function automatic logic [9:0] frame_of(input logic [7:0] d);
      logic par;
      par = (($countones(d) % 2) == 0);
      return {1'b1, par, d};
   endfunction

   task automatic issue_cmd(input logic [7:0] d, input logic hold, input string tag);
      cmd_data  = d;
      cmd_valid = 1'b1;
      tick(1);
      check({tag, "_accept"}, cmd_ready, 1'b0);
      if (!hold) cmd_valid = 1'b0;
   endtask

   // Device: wait for request-to-send, then produce nfalls clock pulses,
   // sampling data on each rising edge and driving ACK before fall 11.
   task automatic device(input logic ack, input int nfalls, input string tag,
                         output logic [9:0] seen, output int fall1);
      logic ok;
      ok    = 1'b0;
      seen  = '1;
      fall1 = 0;
      for (int i = 0; i < int'(INH) + 50; i++) begin
         tick(1);
         if (!ps2_clk_oe && ps2_dat_in == 1'b0) begin
            ok = 1'b1;
            break;
         end
      end
      check({tag, "_rts_seen"}, ok, 1'b1);
      if (!ok) return;
      tick(4);
      for (int k = 1; k <= nfalls; k++) begin
         if (k == 11) dev_dat = ack ? 1'b0 : 1'b1;
         dev_clk = 1'b0;
         if (k == 1) fall1 = cyc;
         tick(HALF);
         dev_clk = 1'b1;
         if (k <= 10) seen[k-1] = ps2_dat_in;
         tick(HALF);
      end
      dev_dat = 1'b1;
   endtask

   task automatic wait_end(input int base, input int bound, input string tag);
      logic got;
      got = 1'b0;
      for (int i = 0; i < bound; i++) begin
         tick(1);
         if (done_n + err_n > base) begin
            got = 1'b1;
            break;
         end
      end
      check({tag, "_end_seen"}, got, 1'b1);
   endtask

   task automatic xfer(input logic [7:0] d, input logic ack, input string tag);
      int d0, e0, i0, r0, f1;
      logic [9:0] seen;
      d0 = done_n; e0 = err_n; i0 = inh_n; r0 = rts_n;
      issue_cmd(d, 1'b0, tag);
      device(ack, 11, tag, seen, f1);
      wait_end(d0 + e0, 200, tag);
      tick(2);
      check({tag, "_frame"}, seen, frame_of(d));
      check({tag, "_inhibit_len"}, inh_n - i0, INH);
      check({tag, "_rts_len"}, rts_n - r0, 1);
      check({tag, "_done"}, done_n - d0, ack ? 1 : 0);
      check({tag, "_error"}, err_n - e0, ack ? 0 : 1);
      check({tag, "_ready_after"}, cmd_ready, 1'b1);
   endtask

   initial begin
      int d0, e0, f1, f2;
      logic [9:0] seen, seen2;
      logic [7:0] rb;
      logic found;

      resetn    = 1'b0;
      cmd_valid = 1'b0;
      cmd_data  = 8'h00;
      dev_clk   = 1'b1;
      dev_dat   = 1'b1;
      tick(3);
      check("rst_clk_oe", ps2_clk_oe, 1'b0);
      check("rst_dat_oe", ps2_dat_oe, 1'b0);
      check("rst_busy", tx_busy, 1'b0);
      check("rst_done", tx_done, 1'b0);
      check("rst_error", tx_error, 1'b0);
      check("rst_ready", cmd_ready, 1'b1);
      resetn = 1'b1;
      tick(3);

      // Directed command bytes with ACK.
      xfer(8'hED, 1'b1, "ed");
      xfer(8'hF4, 1'b1, "f4");
      xfer(8'h00, 1'b1, "z00");

      // Random command bytes with ACK.
      for (int i = 0; i < 4; i++) begin
         rb = 8'($urandom);
         xfer(rb, 1'b1, "rand");
      end

      // NACK: device leaves data high at fall 11.
      xfer(8'hFF, 1'b0, "nack");

      // No device clock after release.
      d0 = done_n; e0 = err_n;
      issue_cmd(8'hF4, 1'b0, "sto");
      wait_end(d0 + e0, int'(INH + STO) + 50, "sto");
      check("sto_latency", err_cyc - rel_cyc, STO);
      check("sto_error_pulse", tx_error, 1'b1);
      check("sto_clk_oe", ps2_clk_oe, 1'b0);
      check("sto_dat_oe", ps2_dat_oe, 1'b0);
      tick(1);
      check("sto_ready_next", cmd_ready, 1'b1);
      check("sto_error_once", tx_error, 1'b0);
      check("sto_no_done", done_n - d0, 0);
      tick(2);

      // Device stops clocking after fall 5.
      d0 = done_n; e0 = err_n;
      issue_cmd(8'hC3, 1'b0, "xto");
      device(1'b1, 5, "xto", seen, f1);
      wait_end(d0 + e0, int'(2 * XTO), "xto");
      check("xto_latency_window", ((err_cyc - f1) >= int'(XTO)) && ((err_cyc - f1) <= int'(XTO) + 5), 1'b1);
      check("xto_error", err_n - e0, 1);
      check("xto_no_done", done_n - d0, 0);
      tick(3);

      // Asynchronous reset while shifting.
      issue_cmd(8'h30, 1'b0, "arst");
      device(1'b1, 4, "arst", seen, f1);
      check("arst_busy_pre", tx_busy, 1'b1);
      check("arst_dat_oe_pre", ps2_dat_oe, 1'b1);
      resetn = 1'b0;
      #1;
      check("arst_clk_oe", ps2_clk_oe, 1'b0);
      check("arst_dat_oe", ps2_dat_oe, 1'b0);
      check("arst_busy", tx_busy, 1'b0);
      check("arst_ready", cmd_ready, 1'b1);
      tick(2);
      resetn = 1'b1;
      tick(3);

      // New request during SHIFT is ignored; in-flight byte completes unchanged.
      d0 = done_n; e0 = err_n;
      issue_cmd(8'hA3, 1'b0, "ign");
      fork
         device(1'b1, 11, "ign", seen, f1);
         begin
            tick(INH + 5 + 8 * HALF);
            cmd_data  = 8'h55;
            cmd_valid = 1'b1;
            tick(4 * HALF);
            check("ign_ready_low", cmd_ready, 1'b0);
            cmd_valid = 1'b0;
         end
      join
      wait_end(d0 + e0, 200, "ign");
      tick(2);
      check("ign_frame", seen, frame_of(8'hA3));
      check("ign_done", done_n - d0, 1);
      tick(5);
      check("ign_no_restart", tx_busy, 1'b0);

      // cmd_valid held high across DONE starts the next transfer one cycle after IDLE.
      d0 = done_n; e0 = err_n;
      issue_cmd(8'h5A, 1'b1, "hold");
      device(1'b1, 11, "hold", seen, f1);
      found = 1'b0;
      for (int i = 0; i < 200; i++) begin
         if (tx_done) begin
            found = 1'b1;
            break;
         end
         tick(1);
      end
      check("hold_done_seen", found, 1'b1);
      tick(1);
      check("hold_idle_ready", cmd_ready, 1'b1);
      check("hold_idle_clk_oe", ps2_clk_oe, 1'b0);
      tick(1);
      check("hold_restart_clk_oe", ps2_clk_oe, 1'b1);
      check("hold_restart_ready", cmd_ready, 1'b0);
      cmd_valid = 1'b0;
      device(1'b1, 11, "hold2", seen2, f2);
      wait_end(d0 + e0 + 1, 200, "hold2");
      tick(2);
      check("hold_frame1", seen, frame_of(8'h5A));
      check("hold_frame2", seen2, frame_of(8'h5A));
      check("hold_done_count", done_n - d0, 2);
      check("hold_fall_order", f2 > f1, 1'b1);

      check("never_done_and_error", both_n, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
